// File: rtl/pht_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pht_controller_pkg                                     |
// | Description : Shared constants for the PHT controller: FSM state     |
// |               encodings, clear-sweep pass count and the layout of    |
// |               one buffered resolve entry ({index, taken}).           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pht_controller_pkg;

  // FSM state encodings
  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_CLEAR = 1'b1;

  // Three decrementing passes take any 2-bit counter (max 11) down to 00
  localparam int unsigned c_SWEEP_PASSES = 3;

  // Update entry layout: taken flag in bit 0, PHT index in the bits above
  localparam int unsigned c_ENTRY_TAKEN_BIT = 0;

endpackage : pht_controller_pkg
`default_nettype wire

// File: rtl/pht_controller_update_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pht_controller_update_fifo                             |
// | Description : Synchronous FIFO buffering resolved-branch updates.    |
// |               Head is presented combinationally on o_rdata.          |
// | Ports       : clk, rst_n (async active-low), i_push, i_pop, i_flush, |
// |               i_wdata, o_rdata, o_full, o_empty                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pht_controller_update_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; entries are only read while valid
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

endmodule : pht_controller_update_fifo
`default_nettype wire

// File: rtl/pht_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pht_controller                                         |
// | Description : gshare index generation, resolved-update buffering and |
// |               PHT write-port arbitration, plus a clear sweep that    |
// |               drives every PHT counter to strongly-not-taken.        |
// | Ports       : clk, rst_n (async active-low)                          |
// |               lookup   : i_lookup_pc -> o_predict_taken/_index       |
// |               resolve  : i_resolve_* / o_resolve_ready               |
// |               control  : i_clear_req, o_busy, o_mispredict_count     |
// |               PHT port : o_pht_index_read, i_pht_count,              |
// |                          o_pht_index_write, o_pht_inc_dec,           |
// |                          o_pht_write_enabled                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pht_controller
  import pht_controller_pkg::*;
#(
  parameter int INDEX_LEN  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MISS_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INDEX_LEN-1:0] i_lookup_pc,
  output logic                 o_predict_taken,
  output logic [INDEX_LEN-1:0] o_predict_index,
  input  logic                 i_resolve_valid,
  input  logic [INDEX_LEN-1:0] i_resolve_index,
  input  logic                 i_resolve_taken,
  input  logic                 i_resolve_mispredict,
  output logic                 o_resolve_ready,
  input  logic                 i_clear_req,
  output logic                 o_busy,
  output logic [MISS_W-1:0]    o_mispredict_count,
  output logic [INDEX_LEN-1:0] o_pht_index_read,
  input  logic [1:0]           i_pht_count,
  output logic [INDEX_LEN-1:0] o_pht_index_write,
  output logic                 o_pht_inc_dec,
  output logic                 o_pht_write_enabled
);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [INDEX_LEN-1:0] r_ghr;
  logic [INDEX_LEN-1:0] r_sweep_idx;
  logic [1:0]           r_pass;
  logic [MISS_W-1:0]    r_miss;

  logic                 w_idle;
  logic                 w_clear_start;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_sweep_last;
  logic [INDEX_LEN:0]   w_head;
  logic [INDEX_LEN-1:0] w_index;
  logic                 w_unused_count_lsb;

  // Only the MSB of the 2-bit counter forms the prediction
  assign w_unused_count_lsb = i_pht_count[0];

  assign w_idle        = (r_state == c_ST_IDLE);
  assign w_clear_start = w_idle && i_clear_req;
  assign w_index       = i_lookup_pc ^ r_ghr;
  assign w_accept      = i_resolve_valid && o_resolve_ready;
  // The cycle that starts a sweep drops pending entries instead of writing one
  assign w_pop         = w_idle && !w_empty && !i_clear_req;
  assign w_sweep_last  = (r_sweep_idx == '1) &&
                         (r_pass == 2'(c_SWEEP_PASSES - 1));

  assign o_predict_index    = w_index;
  assign o_pht_index_read   = w_index;
  assign o_predict_taken    = w_idle && i_pht_count[1];
  assign o_resolve_ready    = !w_full && w_idle;
  assign o_busy             = (r_state == c_ST_CLEAR);
  assign o_mispredict_count = r_miss;

  pht_controller_update_fifo #(
    .WIDTH (INDEX_LEN + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_update_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept && !w_clear_start),
    .i_pop   (w_pop),
    .i_flush (w_clear_start),
    .i_wdata ({i_resolve_index, i_resolve_taken}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (i_clear_req)  w_state_nxt = c_ST_CLEAR;
      c_ST_CLEAR: if (w_sweep_last) w_state_nxt = c_ST_IDLE;
      default:                      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM: PHT write-port outputs; idle outputs held at zero when nothing drains
  always_comb begin
    o_pht_write_enabled = 1'b0;
    o_pht_index_write   = '0;
    o_pht_inc_dec       = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        o_pht_write_enabled = w_pop;
        o_pht_index_write   = w_pop ? w_head[INDEX_LEN:1] : '0;
        o_pht_inc_dec       = w_pop && w_head[c_ENTRY_TAKEN_BIT];
      end
      c_ST_CLEAR: begin
        o_pht_write_enabled = 1'b1;
        o_pht_index_write   = r_sweep_idx;
        o_pht_inc_dec       = 1'b0;
      end
      default: ;
    endcase
  end

  // Global history, sweep counters and saturating mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr       <= '0;
      r_sweep_idx <= '0;
      r_pass      <= '0;
      r_miss      <= '0;
    end else begin
      if (w_clear_start) begin
        r_ghr       <= '0;
        r_sweep_idx <= '0;
        r_pass      <= '0;
      end else begin
        if (w_accept) r_ghr <= {r_ghr[INDEX_LEN-2:0], i_resolve_taken};
        if (o_busy) begin
          r_sweep_idx <= r_sweep_idx + 1'b1;
          if ((r_sweep_idx == '1) && (r_pass != 2'(c_SWEEP_PASSES - 1)))
            r_pass <= r_pass + 1'b1;
        end
      end
      if (w_accept && i_resolve_mispredict && (r_miss != '1))
        r_miss <= r_miss + 1'b1;
    end
  end

endmodule : pht_controller
`default_nettype wire

// File: tb/tb_pht_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pht_controller                                      |
// | Description : Self-checking bench for pht_controller. The bench also |
// |               plays the PHT memory; a queue/arithmetic reference     |
// |               model predicts every controller output each cycle.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pht_controller;

  localparam int c_N     = 1024;
  localparam int c_SWEEP = 3 * c_N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] lookup_pc;
  logic       predict_taken;
  logic [9:0] predict_index;
  logic       resolve_valid;
  logic [9:0] resolve_index;
  logic       resolve_taken;
  logic       resolve_mispredict;
  logic       resolve_ready;
  logic       clear_req;
  logic       busy;
  logic [15:0] mispredict_count;
  logic [9:0] pht_index_read;
  logic [1:0] pht_count;
  logic [9:0] pht_index_write;
  logic       pht_inc_dec;
  logic       pht_write_enabled;

  always #5 clk = ~clk;

  pht_controller #(.INDEX_LEN(10), .FIFO_DEPTH(4), .MISS_W(16)) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_lookup_pc          (lookup_pc),
    .o_predict_taken      (predict_taken),
    .o_predict_index      (predict_index),
    .i_resolve_valid      (resolve_valid),
    .i_resolve_index      (resolve_index),
    .i_resolve_taken      (resolve_taken),
    .i_resolve_mispredict (resolve_mispredict),
    .o_resolve_ready      (resolve_ready),
    .i_clear_req          (clear_req),
    .o_busy               (busy),
    .o_mispredict_count   (mispredict_count),
    .o_pht_index_read     (pht_index_read),
    .i_pht_count          (pht_count),
    .o_pht_index_write    (pht_index_write),
    .o_pht_inc_dec        (pht_inc_dec),
    .o_pht_write_enabled  (pht_write_enabled)
  );

  // PHT memory model driven by the controller's write port
  logic [1:0] pht_mem [c_N];
  int         wcount  [c_N];
  assign pht_count = pht_mem[pht_index_read];

  always @(posedge clk) begin
    if (pht_write_enabled) begin
      if (pht_inc_dec) begin
        if (pht_mem[pht_index_write] != 2'd3) pht_mem[pht_index_write] <= pht_mem[pht_index_write] + 2'd1;
      end else begin
        if (pht_mem[pht_index_write] != 2'd0) pht_mem[pht_index_write] <= pht_mem[pht_index_write] - 2'd1;
        wcount[pht_index_write] <= wcount[pht_index_write] + 1;
      end
    end
  end

  // Reference model state
  int q[$];        // pending updates, entry = index*2 + taken
  int m_ghr;
  int m_miss;
  int m_rem;       // remaining sweep cycles, 0 when idle

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ghr  = 0;
    m_miss = 0;
    m_rem  = 0;
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling
  // edge, then advance the model across the next rising edge.
  task automatic step(input bit v, input int idx, input bit tk, input bit mis,
                      input int pc, input bit clr);
    int  e_idx, e_wi;
    bit  e_busy, e_rdy, e_we, e_id;
    resolve_valid      = v;
    resolve_index      = 10'(idx);
    resolve_taken      = tk;
    resolve_mispredict = mis;
    lookup_pc          = 10'(pc);
    clear_req          = clr;
    @(negedge clk);
    e_idx  = (pc ^ m_ghr) & (c_N - 1);
    e_busy = (m_rem > 0);
    e_rdy  = !e_busy && (q.size() < 4);
    e_we = 0; e_wi = 0; e_id = 0;
    if (e_busy) begin
      e_we = 1; e_wi = (c_SWEEP - m_rem) % c_N;
    end else if (!clr && q.size() > 0) begin
      e_we = 1; e_wi = q[0] / 2; e_id = q[0][0];
    end
    check("pred_index", 32'(predict_index), 32'(e_idx));
    check("read_index", 32'(pht_index_read), 32'(e_idx));
    check("pred_taken", 32'(predict_taken), e_busy ? 0 : 32'(pht_mem[e_idx][1]));
    check("busy", 32'(busy), 32'(e_busy));
    check("ready", 32'(resolve_ready), 32'(e_rdy));
    check("wr_en", 32'(pht_write_enabled), 32'(e_we));
    check("wr_index", 32'(pht_index_write), 32'(e_wi));
    check("inc_dec", 32'(pht_inc_dec), 32'(e_id));
    check("miss_cnt", 32'(mispredict_count), 32'(m_miss));
    @(posedge clk);
    if (e_busy) begin
      m_rem--;
    end else if (clr) begin
      m_rem = c_SWEEP;
      q.delete();
      m_ghr = 0;
    end else begin
      if (e_we) void'(q.pop_front());
      if (v && e_rdy) begin
        q.push_back(((idx & (c_N - 1)) * 2) + int'(tk));
        m_ghr = ((m_ghr << 1) | int'(tk)) & (c_N - 1);
        if (mis && m_miss < 65535) m_miss++;
      end
    end
    #1;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    resolve_valid = 0; resolve_index = '0; resolve_taken = 0;
    resolve_mispredict = 0; clear_req = 0; lookup_pc = 10'h005;
    for (int i = 0; i < c_N; i++) begin
      pht_mem[i] = 2'($urandom_range(0, 3));
      wcount[i]  = 0;
    end
    pht_mem[5] = 2'b10;
    model_reset();
    #3;
    check("rst_pred_taken", 32'(predict_taken), 1);
    check("rst_pred_index", 32'(predict_index), 32'h005);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(resolve_ready), 1);
    check("rst_wr_en", 32'(pht_write_enabled), 0);
    check("rst_inc_dec", 32'(pht_inc_dec), 0);
    check("rst_wr_index", 32'(pht_index_write), 0);
    check("rst_miss", 32'(mispredict_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single update on an empty FIFO
    step(1, 10'h0A3, 1, 0, 0, 0);
    lookup_pc = 10'h000; resolve_valid = 0; #1;
    check("a3_ghr", 32'(predict_index), 32'h001);
    check("a3_wr_en", 32'(pht_write_enabled), 1);
    check("a3_wr_index", 32'(pht_index_write), 32'h0A3);
    check("a3_inc_dec", 32'(pht_inc_dec), 1);
    step(0, 0, 0, 0, 0, 0);

    // Five back-to-back updates, then let them drain
    for (int i = 0; i < 5; i++) step(1, 16 * i + 7, i[0], 1, $urandom, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, $urandom, 0);

    // Ten taken updates saturate the history to all-ones
    for (int i = 0; i < 10; i++) step(1, $urandom, 1, 0, $urandom, 0);
    lookup_pc = 10'h3FF; resolve_valid = 0; #1;
    check("ghr_ones_index", 32'(predict_index), 32'h000);
    step(0, 0, 0, 0, 10'h3FF, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom, $urandom % 2, $urandom % 2, $urandom, 0);

    // Clear sweep with an update still pending
    for (int i = 0; i < c_N; i++) wcount[i] = 0;
    step(1, 10'h111, 1, 0, $urandom, 0);
    step(1, 10'h222, 1, 0, $urandom, 0);
    step(0, 0, 0, 0, $urandom, 1);
    for (int i = 0; i < c_SWEEP; i++) step(0, 0, 0, 0, $urandom, i == 100);
    bad = 0;
    for (int i = 0; i < c_N; i++)
      if (wcount[i] != 3 || pht_mem[i] != 2'b00) bad++;
    check("sweep_entries_bad", 32'(bad), 0);
    check("sweep_ready", 32'(resolve_ready), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, $urandom, 0);

    // Asynchronous reset in the middle of a sweep
    step(0, 0, 0, 0, $urandom, 1);
    for (int i = 0; i < 500; i++) step(0, 0, 0, 0, $urandom, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wr_en", 32'(pht_write_enabled), 0);
    check("midrst_ready", 32'(resolve_ready), 1);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Mispredict counter saturation
    for (int i = 0; i < 65540; i++) step(1, $urandom, $urandom % 2, 1, $urandom, 0);
    check("miss_saturated", 32'(mispredict_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pht_controller
`default_nettype wire
